// File: rtl/strobe_capture_pkg.sv
// Shared constants for the strobe sample capture stage: widths, edge-mode codes
// and the occupancy-width helper used by the FIFO and the top.
package strobe_capture_pkg;

  localparam int DATA_W_DEF   = 10;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_BOTH    = 2;

  localparam int DROP_CNT_W   = 8;

  // Occupancy needs one extra bit so that "full" (level == depth) is representable.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through sample buffer; head visible the cycle after the push.
// Push while full is ignored unless a pop happens in the same cycle; pop while empty is ignored.
module sample_fifo
  import strobe_capture_pkg::*;
#(
  parameter int WIDTH = DATA_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_dat,
  input  logic                        pop,
  output logic [WIDTH-1:0]            head_dat,
  output logic                        full,
  output logic                        empty,
  output logic [level_w(DEPTH)-1:0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Pointer MSBs differ only when the writer has lapped the reader.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level   = wr_ptr_q - rd_ptr_q;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
  end

  // Storage is not reset, so the head is masked to zero whenever nothing is valid.
  assign head_dat = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/strobe_sample_capture.sv
// Synchronises an async strobe + data bus, captures on the selected edge into a FWFT FIFO.
// Sample valid SYNC_STAGES clks after strobe is first sampled; full FIFO without pop drops and counts.
module strobe_sample_capture
  import strobe_capture_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int SYNC_STAGES    = 2,
  parameter int FIFO_DEPTH     = 4,
  parameter int EDGE_MODE      = EDGE_RISING,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             ena,
  input  logic                             strobe_in,
  input  logic [DATA_W-1:0]                data_in,
  output logic [DATA_W-1:0]                sample_out,
  output logic                             sample_valid,
  input  logic                             sample_ready,
  output logic [level_w(FIFO_DEPTH)-1:0]   level,
  output logic                             overflow,
  output logic [DROP_CNT_W-1:0]            drop_count,
  output logic                             stall,
  input  logic                             clr_flags
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] strb_sync_q;
  logic [DATA_W-1:0]      data_sync_q [SYNC_STAGES];
  logic                   strb_prev_q;
  logic                   strb_now;
  logic                   edge_det;

  logic                   push_req;
  logic                   pop_req;
  logic                   drop;
  logic                   fifo_full;
  logic                   fifo_empty;

  logic                   overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
  logic                   stall_q, stall_d;

  // The data chain has the same depth as the strobe chain, so the word leaving it
  // lines up with the edge; this relies on the bus being held still around the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strb_sync_q <= '0;
      strb_prev_q <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) data_sync_q[i] <= '0;
    end else begin
      strb_sync_q <= {strb_sync_q[SYNC_STAGES-2:0], strobe_in};
      strb_prev_q <= strb_now;
      data_sync_q[0] <= data_in;
      for (int i = 1; i < SYNC_STAGES; i++) data_sync_q[i] <= data_sync_q[i-1];
    end
  end

  assign strb_now = strb_sync_q[SYNC_STAGES-1];

  always_comb begin
    edge_det = 1'b0;
    if (EDGE_MODE == EDGE_FALLING)   edge_det = ~strb_now & strb_prev_q;
    else if (EDGE_MODE == EDGE_BOTH) edge_det = strb_now ^ strb_prev_q;
    else                             edge_det = strb_now & ~strb_prev_q;
  end

  assign push_req = edge_det & ena;
  assign pop_req  = sample_valid & sample_ready;
  assign drop     = push_req & fifo_full & ~pop_req;

  sample_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_req),
    .push_dat (data_sync_q[SYNC_STAGES-1]),
    .pop      (pop_req),
    .head_dat (sample_out),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (level)
  );

  assign sample_valid = ~fifo_empty;

  // A drop in the same cycle as a clear wins, so the event is never lost.
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (clr_flags)             drop_cnt_d = DROP_CNT_W'(1);
      else if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
    end else if (clr_flags) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_comb begin
    to_cnt_d = to_cnt_q;
    stall_d  = stall_q;
    if (ena) begin
      if (push_req) begin
        to_cnt_d = '0;
        stall_d  = 1'b0;
      end else if (to_cnt_q == TO_LAST) begin
        stall_d  = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      to_cnt_q   <= '0;
      stall_q    <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      to_cnt_q   <= to_cnt_d;
      stall_q    <= stall_d;
    end
  end

  assign overflow   = overflow_q;
  assign drop_count = drop_cnt_q;
  assign stall      = stall_q;

endmodule

// File: tb/tb_strobe_sample_capture.sv
// Bench for strobe_sample_capture: rising-edge main instance plus both-edge and falling-edge instances.
module tb_strobe_sample_capture;
  import strobe_capture_pkg::*;

  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b0;
  logic          strobe_in = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          sample_ready = 1'b0;
  logic          clr_flags = 1'b0;

  logic [DW-1:0] sample_out;
  logic          sample_valid;
  logic [2:0]    level;
  logic          overflow;
  logic [7:0]    drop_count;
  logic          stall;

  logic          strobe2 = 1'b0;
  logic [DW-1:0] data2 = '0;
  logic          rdy2 = 1'b0;

  logic [DW-1:0] out_b, out_f;
  logic          vld_b, vld_f;
  logic [2:0]    lvl_b, lvl_f;
  logic          ovf_b, ovf_f, stl_b, stl_f;
  logic [7:0]    drp_b, drp_f;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_b[$];
  logic [DW-1:0] exp_f[$];

  always #10 clk = ~clk;

  strobe_sample_capture #(
    .DATA_W(DW), .SYNC_STAGES(2), .FIFO_DEPTH(4),
    .EDGE_MODE(EDGE_RISING), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .strobe_in(strobe_in), .data_in(data_in),
    .sample_out(sample_out), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .level(level), .overflow(overflow), .drop_count(drop_count), .stall(stall),
    .clr_flags(clr_flags)
  );

  strobe_sample_capture #(
    .DATA_W(DW), .SYNC_STAGES(2), .FIFO_DEPTH(4),
    .EDGE_MODE(EDGE_BOTH), .TIMEOUT_CYCLES(1024)
  ) dut_both (
    .clk(clk), .rst_n(rst_n), .ena(1'b1), .strobe_in(strobe2), .data_in(data2),
    .sample_out(out_b), .sample_valid(vld_b), .sample_ready(rdy2),
    .level(lvl_b), .overflow(ovf_b), .drop_count(drp_b), .stall(stl_b),
    .clr_flags(1'b0)
  );

  strobe_sample_capture #(
    .DATA_W(DW), .SYNC_STAGES(2), .FIFO_DEPTH(4),
    .EDGE_MODE(EDGE_FALLING), .TIMEOUT_CYCLES(1024)
  ) dut_fall (
    .clk(clk), .rst_n(rst_n), .ena(1'b1), .strobe_in(strobe2), .data_in(data2),
    .sample_out(out_f), .sample_valid(vld_f), .sample_ready(rdy2),
    .level(lvl_f), .overflow(ovf_f), .drop_count(drp_f), .stall(stl_f),
    .clr_flags(1'b0)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitors: a handshake seen at the falling edge is the pop at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && sample_valid && sample_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL main_extra_pop: got 0x%0h expected no sample", sample_out);
      end else chk("main_sample", int'(sample_out), int'(exp_q.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (rst_n && vld_b && rdy2) begin
      if (exp_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL both_extra_pop: got 0x%0h expected no sample", out_b);
      end else chk("both_sample", int'(out_b), int'(exp_b.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (rst_n && vld_f && rdy2) begin
      if (exp_f.size() == 0) begin
        checks++; errors++;
        $display("FAIL fall_extra_pop: got 0x%0h expected no sample", out_f);
      end else chk("fall_sample", int'(out_f), int'(exp_f.pop_front()));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Data is held 4 clks before and after each strobe transition.
  task automatic pulse(input logic [DW-1:0] d);
    data_in = d;
    tick(4);
    strobe_in = 1'b1;
    tick(4);
    strobe_in = 1'b0;
    tick(4);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"},    int'(sample_valid), 0);
    chk({tag, "_out"},      int'(sample_out),   0);
    chk({tag, "_level"},    int'(level),        0);
    chk({tag, "_overflow"}, int'(overflow),     0);
    chk({tag, "_drops"},    int'(drop_count),   0);
    chk({tag, "_stall"},    int'(stall),        0);
  endtask

  initial begin
    // Reset state
    tick(3);
    chk_all_zero("reset");
    rst_n = 1'b1;
    ena = 1'b1;

    // Single strobe latency: valid after the third rising edge that sees the strobe
    sample_ready = 1'b1;
    data_in = 10'h2A5;
    tick(4);
    exp_q.push_back(10'h2A5);
    strobe_in = 1'b1;
    tick(1);
    chk("lat_valid_n", int'(sample_valid), 0);
    tick(1);
    chk("lat_valid_n1", int'(sample_valid), 0);
    tick(1);
    chk("lat_valid_n2", int'(sample_valid), 1);
    chk("lat_out_n2", int'(sample_out), 10'h2A5);
    tick(1);
    chk("lat_valid_n3", int'(sample_valid), 0);
    chk("lat_level_n3", int'(level), 0);
    strobe_in = 1'b0;
    tick(4);

    // Backpressure and overflow: six samples into four entries
    sample_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (k <= 4) exp_q.push_back(DW'(k));
      pulse(DW'(k));
    end
    chk("ovf_level", int'(level), 4);
    chk("ovf_flag", int'(overflow), 1);
    chk("ovf_drops", int'(drop_count), 2);
    sample_ready = 1'b1;
    tick(6);
    sample_ready = 1'b0;
    chk("ovf_drained_level", int'(level), 0);
    chk("ovf_still_sticky", int'(overflow), 1);
    clr_flags = 1'b1;
    tick(1);
    clr_flags = 1'b0;
    chk("clr_overflow", int'(overflow), 0);
    chk("clr_drops", int'(drop_count), 0);

    // Full FIFO with push and pop in the same cycle
    for (int k = 8; k <= 11; k++) begin
      exp_q.push_back(DW'(k));
      pulse(DW'(k));
    end
    chk("full_level", int'(level), 4);
    data_in = 10'd7;
    tick(4);
    strobe_in = 1'b1;
    tick(1);
    tick(1);
    sample_ready = 1'b1;
    tick(1);
    sample_ready = 1'b0;
    exp_q.push_back(10'd7);
    chk("pp_level", int'(level), 4);
    chk("pp_overflow", int'(overflow), 0);
    chk("pp_drops", int'(drop_count), 0);
    strobe_in = 1'b0;
    tick(4);
    sample_ready = 1'b1;
    tick(6);
    sample_ready = 1'b0;
    chk("pp_drained_level", int'(level), 0);
    chk("pp_queue_empty", exp_q.size(), 0);

    // Edge modes: toggle every 250 ns; both-edge pushes 4, falling-edge pushes 2
    rdy2 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      data2 = DW'(k);
      #125;
      exp_b.push_back(DW'(k));
      if (strobe2) exp_f.push_back(DW'(k));
      strobe2 = ~strobe2;
      #125;
    end
    tick(6);
    chk("both_level", int'(lvl_b), 4);
    chk("fall_level", int'(lvl_f), 2);
    chk("both_overflow", int'(ovf_b), 0);
    rdy2 = 1'b1;
    tick(6);
    rdy2 = 1'b0;
    chk("both_drained", int'(lvl_b), 0);
    chk("fall_drained", int'(lvl_f), 0);
    chk("both_queue_empty", exp_b.size(), 0);
    chk("fall_queue_empty", exp_f.size(), 0);

    // ena gating and stall timeout (16 clks)
    ena = 1'b0;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) pulse(DW'(k));
    chk("gate_level", int'(level), 0);
    chk("gate_stall", int'(stall), 0);
    chk("gate_drops", int'(drop_count), 0);
    ena = 1'b1;
    tick(15);
    chk("stall_pre", int'(stall), 0);
    tick(1);
    chk("stall_set", int'(stall), 1);
    sample_ready = 1'b1;
    exp_q.push_back(10'h3FF);
    pulse(10'h3FF);
    chk("stall_clear", int'(stall), 0);
    chk("stall_level", int'(level), 0);

    // Asynchronous reset with three entries and overflow set
    sample_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) exp_q.push_back(DW'(10'h0A1 + k));
      pulse(DW'(10'h0A1 + k));
    end
    chk("mid_full_level", int'(level), 4);
    chk("mid_drops", int'(drop_count), 1);
    sample_ready = 1'b1;
    tick(1);
    sample_ready = 1'b0;
    chk("mid_level3", int'(level), 3);
    chk("mid_overflow", int'(overflow), 1);
    @(posedge clk);
    #7;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    exp_q.delete();
    tick(2);
    rst_n = 1'b1;
    sample_ready = 1'b1;
    exp_q.push_back(10'h155);
    pulse(10'h155);
    tick(4);
    chk("post_rst_level", int'(level), 0);
    chk("post_rst_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
